// File: rtl/sample_capture_ctrl.sv
// Capture sequencer: arms on a PS start edge, optionally waits for a trigger,
// gates a fixed number of ADC samples, then emits a one-cycle done pulse.
module sample_capture_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_start_reg,
  input  logic             i_abort_reg,
  input  logic [CNT_W-1:0] i_sample_num,
  input  logic             i_trig_en,
  input  logic             i_trig,
  input  logic             i_sample_valid,
  output logic             o_capture_en,
  output logic [CNT_W-1:0] o_sample_cnt,
  output logic             o_busy,
  output logic             o_done_pulse
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_TRIG = 2'd1,
    S_CAPTURE   = 2'd2,
    S_DONE      = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             trig_en_q, trig_en_d;
  logic             start_dly_q, abort_dly_q;
  logic             capture_en_q, busy_q, done_q;
  logic             start_evt, abort_evt;

  assign start_evt = i_start_reg & ~start_dly_q;
  assign abort_evt = i_abort_reg & ~abort_dly_q;

  // Next-state and datapath; abort overrides everything, including the final sample.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    num_d     = num_q;
    trig_en_d = trig_en_q;
    if (abort_evt) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_evt) begin
            num_d     = i_sample_num;
            trig_en_d = i_trig_en;
            cnt_d     = '0;
            if (i_sample_num == '0)  state_d = S_DONE;
            else if (i_trig_en)      state_d = S_WAIT_TRIG;
            else                     state_d = S_CAPTURE;
          end
        end
        S_WAIT_TRIG: begin
          if (i_trig || !trig_en_q) state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          if (i_sample_valid) begin
            cnt_d = CNT_W'(cnt_q + CNT_W'(1));
            if (cnt_d == num_q) state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Edge-detect history resets high so a level held through reset is not an edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      num_q        <= '0;
      trig_en_q    <= 1'b0;
      start_dly_q  <= 1'b1;
      abort_dly_q  <= 1'b1;
      capture_en_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      num_q        <= num_d;
      trig_en_q    <= trig_en_d;
      start_dly_q  <= i_start_reg;
      abort_dly_q  <= i_abort_reg;
      capture_en_q <= (state_d == S_CAPTURE);
      busy_q       <= (state_d == S_CAPTURE) || (state_d == S_WAIT_TRIG);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign o_capture_en = capture_en_q;
  assign o_sample_cnt = cnt_q;
  assign o_busy       = busy_q;
  assign o_done_pulse = done_q;

endmodule

// File: tb/tb_sample_capture_ctrl.sv
// Directed bench for sample_capture_ctrl: normal, triggered, abort, restart,
// zero-length, simultaneous-event and reset scenarios with hand-computed outputs.
module tb_sample_capture_ctrl;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic             i_start_reg, i_abort_reg, i_trig_en, i_trig, i_sample_valid;
  logic [CNT_W-1:0] i_sample_num;
  logic             o_capture_en, o_busy, o_done_pulse;
  logic [CNT_W-1:0] o_sample_cnt;

  int tests = 0;
  int fails = 0;

  sample_capture_ctrl #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_start_reg    (i_start_reg),
    .i_abort_reg    (i_abort_reg),
    .i_sample_num   (i_sample_num),
    .i_trig_en      (i_trig_en),
    .i_trig         (i_trig),
    .i_sample_valid (i_sample_valid),
    .o_capture_en   (o_capture_en),
    .o_sample_cnt   (o_sample_cnt),
    .o_busy         (o_busy),
    .o_done_pulse   (o_done_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic cap, input logic busy,
                         input logic done, input logic [31:0] cnt);
    chk({tag, ".cap"},  32'(o_capture_en), 32'(cap));
    chk({tag, ".busy"}, 32'(o_busy),       32'(busy));
    chk({tag, ".done"}, 32'(o_done_pulse), 32'(done));
    chk({tag, ".cnt"},  32'(o_sample_cnt), cnt);
  endtask

  initial begin
    rstn = 1'b0;
    i_start_reg = 1'b1;
    i_abort_reg = 1'b0;
    i_sample_num = '0;
    i_trig_en = 1'b0;
    i_trig = 1'b0;
    i_sample_valid = 1'b0;
    @(negedge clk);
    tick();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 0);

    // Start held high across reset release: no start.
    rstn = 1'b1;
    i_sample_num = 16'd4;
    tick();
    tick();
    chk_all("start_held_reset", 1'b0, 1'b0, 1'b0, 0);
    i_start_reg = 1'b0;
    tick();

    // Normal run N=4, no trigger, valid every cycle.
    i_start_reg = 1'b1;
    i_sample_num = 16'd4;
    i_sample_valid = 1'b1;
    tick();
    chk_all("n4_start", 1'b1, 1'b1, 1'b0, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_all($sformatf("n4_s%0d", i), 1'b1, 1'b1, 1'b0, 32'(i));
    end
    tick();
    chk_all("n4_done", 1'b0, 1'b0, 1'b1, 4);
    tick();
    chk_all("n4_idle", 1'b0, 1'b0, 1'b0, 4);
    i_start_reg = 1'b0;
    i_sample_valid = 1'b0;
    tick();

    // Triggered run N=3; valids before the trigger are ignored.
    i_start_reg = 1'b1;
    i_sample_num = 16'd3;
    i_trig_en = 1'b1;
    tick();
    chk_all("trg_start", 1'b0, 1'b1, 1'b0, 0);
    i_sample_num = 16'd99;
    i_trig_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      i_sample_valid = 1'(i % 2);
      tick();
    end
    chk_all("trg_wait", 1'b0, 1'b1, 1'b0, 0);
    i_trig = 1'b1;
    i_sample_valid = 1'b1;
    tick();
    chk_all("trg_hit", 1'b1, 1'b1, 1'b0, 0);
    i_trig = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      i_sample_valid = 1'b0;
      tick();
      tick();
      i_sample_valid = 1'b1;
      tick();
      if (s < 3) chk_all($sformatf("trg_s%0d", s), 1'b1, 1'b1, 1'b0, 32'(s));
    end
    chk_all("trg_done", 1'b0, 1'b0, 1'b1, 3);
    i_sample_valid = 1'b0;
    tick();
    chk_all("trg_idle", 1'b0, 1'b0, 1'b0, 3);
    i_start_reg = 1'b0;
    tick();

    // Abort after 2 of 8 samples, with a valid in the abort cycle.
    i_start_reg = 1'b1;
    i_sample_num = 16'd8;
    i_sample_valid = 1'b1;
    tick();
    tick();
    tick();
    chk_all("abt_2", 1'b1, 1'b1, 1'b0, 2);
    i_abort_reg = 1'b1;
    tick();
    chk_all("abt_idle", 1'b0, 1'b0, 1'b0, 2);
    tick();
    chk_all("abt_hold", 1'b0, 1'b0, 1'b0, 2);
    i_abort_reg = 1'b0;
    i_sample_valid = 1'b0;
    i_start_reg = 1'b0;
    tick();

    // Fresh start clears count; an edge during capture is ignored.
    i_start_reg = 1'b1;
    i_sample_num = 16'd2;
    tick();
    chk_all("rs_start", 1'b1, 1'b1, 1'b0, 0);
    i_start_reg = 1'b0;
    tick();
    i_start_reg = 1'b1;
    i_sample_valid = 1'b1;
    tick();
    chk_all("rs_s1", 1'b1, 1'b1, 1'b0, 1);
    tick();
    chk_all("rs_done", 1'b0, 1'b0, 1'b1, 2);
    i_sample_valid = 1'b0;
    tick();
    tick();
    chk_all("rs_held", 1'b0, 1'b0, 1'b0, 2);
    i_start_reg = 1'b0;
    tick();
    i_start_reg = 1'b1;
    i_sample_num = 16'd5;
    tick();
    chk_all("rs_fresh", 1'b1, 1'b1, 1'b0, 0);
    i_abort_reg = 1'b1;
    tick();
    i_abort_reg = 1'b0;
    i_start_reg = 1'b0;
    tick();

    // Zero-length capture.
    i_start_reg = 1'b1;
    i_sample_num = 16'd0;
    tick();
    chk_all("z_done", 1'b0, 1'b0, 1'b1, 0);
    tick();
    chk_all("z_idle", 1'b0, 1'b0, 1'b0, 0);
    i_start_reg = 1'b0;
    tick();

    // Simultaneous start and abort in IDLE: abort wins.
    i_start_reg = 1'b1;
    i_abort_reg = 1'b1;
    i_sample_num = 16'd5;
    tick();
    chk_all("sa_idle", 1'b0, 1'b0, 1'b0, 0);
    i_start_reg = 1'b0;
    i_abort_reg = 1'b0;
    tick();

    // Final sample coincident with abort.
    i_start_reg = 1'b1;
    i_sample_num = 16'd2;
    i_sample_valid = 1'b1;
    tick();
    tick();
    chk_all("fa_s1", 1'b1, 1'b1, 1'b0, 1);
    i_abort_reg = 1'b1;
    tick();
    chk_all("fa_abort", 1'b0, 1'b0, 1'b0, 1);
    tick();
    chk_all("fa_after", 1'b0, 1'b0, 1'b0, 1);
    i_abort_reg = 1'b0;
    i_start_reg = 1'b0;
    i_sample_valid = 1'b0;
    tick();

    // Asynchronous reset mid-capture.
    i_start_reg = 1'b1;
    i_sample_num = 16'd10;
    i_sample_valid = 1'b1;
    tick();
    tick();
    chk_all("rst_pre", 1'b1, 1'b1, 1'b0, 1);
    rstn = 1'b0;
    #1;
    chk_all("rst_async", 1'b0, 1'b0, 1'b0, 0);
    tick();
    chk_all("rst_hold", 1'b0, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sample_capture_ctrl.md
# sample_capture_ctrl

Upstream event source for the PS-visible flag logic in the PS AXI control IP. It is armed by a PS start register and optionally waits for a trigger. It then gates a fixed number of ADC samples and emits a single-cycle `o_done_pulse`, which drives the `i_flag_pulse` input of the capture-done flag stage. It also exposes a live sample count and a busy status for PS readback.

## Interface
- `CNT_W`, default 16: width of the sample-number and sample-count fields.
- `clk` in 1: system clock.
- `rstn` in 1: asynchronous active-low reset.
- `i_start_reg` in 1: PS register level. A 0→1 edge requests a capture.
- `i_abort_reg` in 1: PS register level. A 0→1 edge aborts the current capture.
- `i_sample_num` in CNT_W: number of samples to capture; latched when a start is accepted.
- `i_trig_en` in 1: if 1, wait for `i_trig` before capturing; latched when a start is accepted.
- `i_trig` in 1: synchronous trigger level, sampled in WAIT_TRIG.
- `i_sample_valid` in 1: ADC sample strobe.
- `o_capture_en` out 1: high while in CAPTURE; a sample is accepted when `i_sample_valid & o_capture_en`.
- `o_sample_cnt` out CNT_W: number of samples accepted in the current or last capture.
- `o_busy` out 1: high in WAIT_TRIG and CAPTURE.
- `o_done_pulse` out 1: single-cycle pulse on normal completion.

## Operation
- Edge detection:
  - Internal registers `r_start_d` and `r_abort_d` track the previous levels of the two PS registers.
  - start_evt = `i_start_reg & ~r_start_d`; abort_evt = `i_abort_reg & ~r_abort_d`.
  - `r_start_d` and `r_abort_d` reset to 1, so a register held high through reset release produces no event.
- States: IDLE, WAIT_TRIG, CAPTURE, DONE.
- IDLE:
  - start_evt with no abort_evt is accepted: latch `i_sample_num` and `i_trig_en`, clear `o_sample_cnt` to 0.
  - Next state after an accepted start:
    - `i_sample_num`==0 → DONE.
    - else `i_trig_en`=1 → WAIT_TRIG.
    - else → CAPTURE.
- WAIT_TRIG: `i_trig`=1 → CAPTURE. No sample is accepted in the trigger cycle.
- CAPTURE: each accepted sample increments `o_sample_cnt`. The accepted sample that makes the count equal the latched number moves the FSM to DONE.
- DONE: lasts exactly one cycle, then IDLE.
- Abort: abort_evt in any state moves the FSM to IDLE next cycle.
  - No done pulse.
  - `o_sample_cnt` holds its value.
  - A sample in the abort cycle is not counted.
- A start_evt outside IDLE, including in DONE, is ignored and not queued.
- Simultaneous start_evt and abort_evt in IDLE: abort wins; the FSM stays in IDLE.
- Simultaneous final sample and abort_evt: abort wins; no DONE, and the count is not incremented.
- The count never wraps: it stops at the latched number, which is at most 2^CNT_W−1.
- A change to `i_sample_num` or `i_trig_en` while busy has no effect on the current capture.

## Timing
- Reset values: state IDLE, `o_capture_en`=0, `o_sample_cnt`=0, `o_busy`=0, `o_done_pulse`=0, latched number 0, latched trig_en 0.
- All outputs are registered or decoded from the registered state; no combinational input→output path.
- Start latency: `i_start_reg` rises before edge k; at edge k the start is accepted. After edge k:
  - `o_busy`=1.
  - `o_capture_en`=1 if trigger is disabled.
  - `o_sample_cnt`=0.
- Trigger latency: `i_trig` high before edge t → `o_capture_en`=1 after edge t. The first sample can be accepted at edge t+1.
- Completion: the final sample is accepted at edge f. After edge f:
  - `o_sample_cnt`=N.
  - `o_capture_en`=0, `o_busy`=0.
  - `o_done_pulse`=1 for exactly one cycle.
  - After edge f+1 the FSM is in IDLE, and a start_evt before edge f+2 is accepted.
- Zero-length capture: DONE follows the accepted start directly. `o_done_pulse` is high for the cycle after edge k; `o_busy` never asserts.
- Back-to-back valid samples are accepted every cycle; throughput is 1 sample/clk.
- Asynchronous reset mid-capture immediately forces all outputs to their reset values. No done pulse is generated.

## Test plan
- Normal run, N=4, trig_en=0, valid every cycle:
  - `o_capture_en` high for exactly 4 cycles.
  - `o_sample_cnt` steps 0→4.
  - One `o_done_pulse` in the cycle after the 4th sample; `o_busy` falls in the same cycle.
- Triggered run, N=3, trig_en=1:
  - With `i_trig` held low for 10 cycles, valid strobes are not counted.
  - `i_trig` high for one cycle → capture starts the next cycle.
  - Sparse valids (every 3rd cycle) → count reaches 3, then one done pulse.
- Abort after 2 of 8 samples → IDLE, `o_sample_cnt`=2 held, no done pulse. A subsequent start clears the count to 0.
- Start edge during CAPTURE, and `i_start_reg` held high (no new edge) after completion → no restart. Only a fresh 0→1 edge starts a new capture.
- N=0 → `o_done_pulse` in the cycle after the start, `o_busy` stays 0. Start and abort edges in the same IDLE cycle → no action.
- Edge and reset cases:
  - `i_start_reg` high across reset release → no start.
  - `rstn` asserted mid-capture → all outputs 0 immediately.
  - Final sample coincident with an abort edge → no done pulse, count unchanged.
